imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The module SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request word present.
REQ-005 in_ready  output  1  encoder can accept a request this cycle.
REQ-006 in_fmt  input  3  format: 0=ALU-I, 1=LUI, 2=LOAD, 3=STORE, 4=BRANCH, 5-7 illegal.
REQ-007 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-008 in_funct3  input  3  funct3 field.
REQ-009 in_imm  input  32  full signed immediate, byte offset for BRANCH, full value for LUI.
REQ-010 out_valid  output  1  encoded word held.
REQ-011 out_ready  input  1  consumer accepts out_inst this cycle.
REQ-012 out_inst  output  32  encoded instruction word.
REQ-013 out_err  output  1  held word is a substituted NOP (illegal format or immediate out of range).
REQ-014 enc_count  output  16  count of error-free words delivered, saturating.
REQ-015 err_count  output  8  count of error words delivered, saturating.

Function
REQ-016 Input handshake SHALL occur when in_valid && in_ready; output handshake when out_valid && out_ready.
REQ-017 in_ready SHALL equal !out_valid || out_ready, so back-to-back throughput is one word per cycle.
REQ-018 Latency SHALL be one cycle: a word accepted at edge N is presented on out_inst/out_valid after edge N.
REQ-019 While out_valid=1 and out_ready=0, out_inst and out_err SHALL hold stable and no input SHALL be accepted.
REQ-020 If the output handshake happens without a new input, out_valid SHALL clear on the next edge; with a new input, it SHALL stay 1 and load the new word.
REQ-021 ALU-I SHALL encode as {imm[11:0], rs1, funct3, rd, 7'b0010011}.
REQ-022 LUI SHALL encode as {imm[31:12], rd, 7'b0110111}.
REQ-023 LOAD SHALL encode as {imm[11:0], rs1, funct3, rd, 7'b0000011}.
REQ-024 STORE SHALL encode as {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}.
REQ-025 BRANCH SHALL encode as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}.
REQ-026 Range check for ALU-I, LOAD and STORE: imm[31:11] SHALL be all-equal, otherwise error.
REQ-027 Range check for BRANCH: imm[31:12] SHALL be all-equal and imm[0]=0, otherwise error.
REQ-028 Range check for LUI: imm[11:0] SHALL be zero, otherwise error.
REQ-029 An illegal in_fmt SHALL always be an error.
REQ-030 On error, out_inst SHALL be 32'h00000013 (NOP) and out_err=1; otherwise out_err=0.
REQ-031 Unused register fields for a format SHALL be ignored.
REQ-032 Round-trip property: for every error-free word, the immediate decoder of the same pipeline SHALL recover the sign-extended in_imm, with LUI giving {imm[31:12],12'b0}.
REQ-033 enc_count SHALL increment by 1 on each output handshake with out_err=0 and saturate at 16'hFFFF.
REQ-034 err_count SHALL increment by 1 on each output handshake with out_err=1 and saturate at 8'hFF.
REQ-035 Counters SHALL update on the output handshake, not on acceptance.

Reset
REQ-036 While reset=1 at a rising edge, the next state SHALL be: out_valid=0, out_inst=0, out_err=0, enc_count=0, err_count=0.
REQ-037 in_ready SHALL be 1 in the first cycle after reset.
REQ-038 Reset SHALL take priority over any simultaneous handshake and discard a held word.

Verification
REQ-039 ALU-I rd=1 rs1=0 f3=0 imm=32'hFFFFFFFF, out_ready=1 -> out_inst=32'hFFF00093, out_err=0, enc_count=1.
REQ-040 STORE rs2=2 rs1=3 f3=3'b010 imm=8, then BRANCH rs1=rs2=0 f3=0 imm=32'hFFFFFFFC on back-to-back cycles -> 32'h0021A423 then 32'hFE000EE3 on consecutive cycles.
REQ-041 LUI rd=5 imm=32'h12345000 -> 32'h123452B7; LUI imm=32'h12345001 -> 32'h00000013, out_err=1, err_count=1.
REQ-042 ALU-I imm=32'h00000800, BRANCH imm=3 and in_fmt=6, each in turn -> NOP with out_err=1 for each, and err_count=3.
REQ-043 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_inst stable; release -> exactly one handshake per cycle, no word lost or duplicated.
REQ-044 Assert reset while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and both counters 0; saturation check: enc_count preset by 65535 handshakes stays 16'hFFFF.

Source files
------------

// File: rtl/imm_encoder.sv
// Immediate encoder: packs register fields and a full 32-bit immediate
// into an RV32I word, one-entry output register with valid/ready flow.
module imm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [15:0] enc_count,
    output logic [7:0]  err_count
);

    localparam logic [2:0]  FMT_ALUI   = 3'd0;
    localparam logic [2:0]  FMT_LUI    = 3'd1;
    localparam logic [2:0]  FMT_LOAD   = 3'd2;
    localparam logic [2:0]  FMT_STORE  = 3'd3;
    localparam logic [2:0]  FMT_BRANCH = 3'd4;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic        err_q, err_d;
    logic [15:0] enc_cnt_q, enc_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic [31:0] enc_inst;
    logic        enc_err;
    logic        ok_i, ok_b, ok_u;
    logic        in_hs, out_hs;

    // ok_i: fits 12-bit signed; ok_b: fits 13-bit signed and even
    always_comb begin
        ok_i = (&in_imm[31:11]) | ~(|in_imm[31:11]);
        ok_b = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
        ok_u = ~(|in_imm[11:0]);
        enc_inst = NOP;
        enc_err  = 1'b1;
        case (in_fmt)
            FMT_ALUI: begin
                enc_err  = ~ok_i;
                enc_inst = {in_imm[11:0], in_rs1, in_funct3,
                            in_rd, 7'b0010011};
            end
            FMT_LUI: begin
                enc_err  = ~ok_u;
                enc_inst = {in_imm[31:12], in_rd, 7'b0110111};
            end
            FMT_LOAD: begin
                enc_err  = ~ok_i;
                enc_inst = {in_imm[11:0], in_rs1, in_funct3,
                            in_rd, 7'b0000011};
            end
            FMT_STORE: begin
                enc_err  = ~ok_i;
                enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:0], 7'b0100011};
            end
            FMT_BRANCH: begin
                enc_err  = ~ok_b;
                enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                            in_funct3, in_imm[4:1], in_imm[11],
                            7'b1100011};
            end
            default: begin
                enc_err  = 1'b1;
                enc_inst = NOP;
            end
        endcase
        if (enc_err) begin
            enc_inst = NOP;
        end
    end

    assign in_ready = ~valid_q | out_ready;
    assign in_hs    = in_valid & in_ready;
    assign out_hs   = valid_q & out_ready;

    always_comb begin
        valid_d   = valid_q;
        inst_d    = inst_q;
        err_d     = err_q;
        enc_cnt_d = enc_cnt_q;
        err_cnt_d = err_cnt_q;
        if (out_hs) begin
            if (err_q) begin
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end else begin
                if (enc_cnt_q != 16'hFFFF) enc_cnt_d = enc_cnt_q + 16'd1;
            end
        end
        if (in_hs) begin
            valid_d = 1'b1;
            inst_d  = enc_inst;
            err_d   = enc_err;
        end else if (out_hs) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            inst_q    <= 32'h0;
            err_q     <= 1'b0;
            enc_cnt_q <= 16'h0;
            err_cnt_q <= 8'h0;
        end else begin
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            err_q     <= err_d;
            enc_cnt_q <= enc_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_inst  = inst_q;
    assign out_err   = err_q;
    assign enc_count = enc_cnt_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: stimulus pushes expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] enc_count;
    logic [7:0]  err_count;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [2:0] ALUI = 3'd0, LUI = 3'd1, LOAD = 3'd2;
    localparam logic [2:0] STORE = 3'd3, BRANCH = 3'd4;

    imm_encoder dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_err(out_err),
        .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: a handshake seen here completes at the next rising edge
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %h err=%b, none expected",
                         out_inst, out_err);
            end else begin
                e = sb.pop_front();
                if (out_inst !== e.inst || out_err !== e.err) begin
                    errors++;
                    $display("FAIL word: got %h err=%b expected %h err=%b",
                             out_inst, out_err, e.inst, e.err);
                end
            end
        end
    end

    task automatic send(input logic [2:0] fmt, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [31:0] imm,
                        input logic [31:0] xi, input logic xe);
        exp_t e;
        bit   done = 0;
        in_valid  = 1'b1;
        in_fmt    = fmt;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_imm    = imm;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                e.inst = xi;
                e.err  = xe;
                sb.push_back(e);
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 20 && sb.size() != 0; n++) begin
            @(posedge clk);
        end
        #1;
        chk("drain", sb.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_fmt = 3'd0; in_rd = 5'd0; in_rs1 = 5'd0;
        in_rs2 = 5'd0; in_funct3 = 3'd0; in_imm = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_enc_count", enc_count, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_in_ready", in_ready, 1);

        send(ALUI, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 0);
        drain();
        chk("alui_enc_count", enc_count, 1);

        send(STORE, 5'd0, 5'd3, 5'd2, 3'b010, 32'd8, 32'h0021_A423, 0);
        send(BRANCH, 5'd31, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC,
             32'hFE00_0EE3, 0);
        send(LOAD, 5'd7, 5'd9, 5'd0, 3'b010, 32'hFFFF_F800,
             32'h8004_A383, 0);
        drain();
        chk("b2b_enc_count", enc_count, 4);

        do_reset();
        send(LUI, 5'd5, 5'd31, 5'd31, 3'd7, 32'h1234_5000, 32'h1234_52B7, 0);
        send(LUI, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5001, 32'h0000_0013, 1);
        drain();
        chk("lui_enc_count", enc_count, 1);
        chk("lui_err_count", err_count, 1);

        do_reset();
        send(ALUI, 5'd1, 5'd1, 5'd0, 3'd0, 32'h0000_0800, 32'h0000_0013, 1);
        send(BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3, 32'h0000_0013, 1);
        send(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 32'd0, 32'h0000_0013, 1);
        drain();
        chk("illegal_err_count", err_count, 3);
        chk("illegal_enc_count", enc_count, 0);

        out_ready = 1'b0;
        send(ALUI, 5'd2, 5'd3, 5'd0, 3'd4, 32'h0000_07FF, 32'h7FF1_C113, 0);
        in_valid = 1'b1;
        in_fmt = ALUI; in_rd = 5'd4; in_rs1 = 5'd0;
        in_imm = 32'h0000_0001; in_funct3 = 3'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_inst", out_inst, 32'h7FF1_C113);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(ALUI, 5'd4, 5'd0, 5'd0, 3'd0, 32'h0000_0001, 32'h0010_0213, 0);
        send(STORE, 5'd0, 5'd1, 5'd1, 3'd0, 32'hFFFF_FFFF, 32'hFE10_8FA3, 0);
        drain();
        chk("stall_enc_count", enc_count, 3);

        out_ready = 1'b0;
        send(ALUI, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h0050_0093, 0);
        reset = 1'b1;
        sb.delete();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        chk("rst_hold_valid", out_valid, 0);
        chk("rst_hold_enc", enc_count, 0);
        chk("rst_hold_err", err_count, 0);
        chk("rst_hold_ready", in_ready, 1);
        out_ready = 1'b1;

        for (int i = 0; i < 65535; i++) begin
            send(ALUI, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 32'h0000_0013, 0);
        end
        drain();
        chk("sat_enc_ffff", enc_count, 16'hFFFF);
        send(ALUI, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 32'h0000_0013, 0);
        drain();
        chk("sat_enc_hold", enc_count, 16'hFFFF);
        chk("sat_err_zero", err_count, 0);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
